// File: rtl/hbridge_dir_sequencer.sv
// rtl/hbridge_dir_sequencer.sv - H-bridge enable gating and per-channel direction sequencing (blank/brake/blank).
// Optional command watchdog: define HB_CMD_WATCHDOG_EN.
module hbridge_dir_sequencer #(
  parameter int DEAD_CYCLES  = 50,
  parameter int BRAKE_CYCLES = 2000,
  parameter int WDT_CYCLES   = 2000000
) (
  input  logic       i_pclk,
  input  logic       i_preset,
  input  logic       i_pwm1_in,
  input  logic       i_pwm2_in,
  input  logic [1:0] i_cmd_a,
  input  logic [1:0] i_cmd_b,
  input  logic       i_cmd_valid,
  output logic       o_pwm1,
  output logic       o_pwm2,
  output logic [3:0] o_h_in,
  output logic [1:0] o_busy,
  output logic       o_fault
);

  localparam int CNT_MAX = (DEAD_CYCLES > BRAKE_CYCLES) ? DEAD_CYCLES : BRAKE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEAD_LOAD  = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] BRAKE_LOAD = CW'(BRAKE_CYCLES - 1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_BLANK1 = 2'd1;
  localparam logic [1:0] S_BRAKE  = 2'd2;
  localparam logic [1:0] S_BLANK2 = 2'd3;

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_REV   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  if (DEAD_CYCLES < 1 || BRAKE_CYCLES < 1 || WDT_CYCLES < 1) begin : g_illegal_params
  end

  function automatic logic is_rev(input logic [1:0] a, input logic [1:0] b);
    return (a == CMD_FWD && b == CMD_REV) || (a == CMD_REV && b == CMD_FWD);
  endfunction

  logic [1:0]    r_state [2];
  logic [1:0]    r_cmd   [2];
  logic [1:0]    r_new   [2];
  logic [CW-1:0] r_cnt   [2];

  logic [1:0]    w_state  [2];
  logic [1:0]    w_cmd    [2];
  logic [1:0]    w_new    [2];
  logic [CW-1:0] w_cnt    [2];
  logic [1:0]    w_cmd_in [2];
  logic [1:0]    w_target [2];
  logic [1:0]    w_pins   [2];
  logic [1:0]    w_en;
  logic [1:0]    w_pwm_in;
  logic          w_wdt_fire;

`ifdef HB_CMD_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] r_wdt;
  logic          r_fault;

  // A strobe always wins over an expiry landing in the same cycle.
  assign w_wdt_fire = !i_cmd_valid && !r_fault && (r_wdt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_wdt   <= '0;
      r_fault <= 1'b0;
    end else if (i_cmd_valid) begin
      r_wdt   <= '0;
      r_fault <= 1'b0;
    end else if (w_wdt_fire) begin
      r_fault <= 1'b1;
    end else if (!r_fault) begin
      r_wdt   <= r_wdt + WW'(1);
    end
  end

  assign o_fault = r_fault;
`else
  assign w_wdt_fire = 1'b0;
  assign o_fault    = 1'b0;
`endif

  always_comb begin
    w_cmd_in[0] = i_cmd_a;
    w_cmd_in[1] = i_cmd_b;
    w_pwm_in    = {i_pwm2_in, i_pwm1_in};
    w_en        = 2'b00;
    for (int c = 0; c < 2; c++) begin
      w_state[c]  = r_state[c];
      w_cmd[c]    = r_cmd[c];
      w_new[c]    = r_new[c];
      w_cnt[c]    = r_cnt[c];
      w_pins[c]   = 2'b00;
      w_target[c] = (r_state[c] == S_RUN) ? r_cmd[c] : r_new[c];
      case (r_state[c])
        S_RUN: begin
          if (i_cmd_valid && w_cmd_in[c] != r_cmd[c]) begin
            w_state[c] = S_BLANK1;
            w_cnt[c]   = DEAD_LOAD;
            w_new[c]   = w_cmd_in[c];
          end
        end
        S_BLANK1: begin
          if (r_cnt[c] == '0) begin
            if (is_rev(r_cmd[c], r_new[c])) begin
              w_state[c] = S_BRAKE;
              w_cnt[c]   = BRAKE_LOAD;
            end else begin
              w_state[c] = S_RUN;
              w_cmd[c]   = r_new[c];
            end
          end else begin
            w_cnt[c] = r_cnt[c] - CW'(1);
          end
        end
        S_BRAKE: begin
          if (r_cnt[c] == '0) begin
            w_state[c] = S_BLANK2;
            w_cnt[c]   = DEAD_LOAD;
          end else begin
            w_cnt[c] = r_cnt[c] - CW'(1);
          end
        end
        default: begin
          if (r_cnt[c] == '0) begin
            w_state[c] = S_RUN;
            w_cmd[c]   = r_new[c];
          end else begin
            w_cnt[c] = r_cnt[c] - CW'(1);
          end
        end
      endcase
      // Watchdog expiry restarts any channel not headed for coast into a plain blank-to-coast.
      if (w_wdt_fire && w_target[c] != CMD_COAST) begin
        w_state[c] = S_BLANK1;
        w_cnt[c]   = DEAD_LOAD;
        w_new[c]   = CMD_COAST;
      end
      case (w_state[c])
        S_RUN: begin
          case (w_cmd[c])
            CMD_FWD, CMD_REV: begin
              w_pins[c] = w_cmd[c];
              w_en[c]   = w_pwm_in[c];
            end
            CMD_BRAKE: begin
              w_pins[c] = 2'b11;
              w_en[c]   = 1'b1;
            end
            default: ;
          endcase
        end
        S_BRAKE: begin
          w_pins[c] = 2'b11;
          w_en[c]   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= S_RUN;
        r_cmd[c]   <= CMD_COAST;
        r_new[c]   <= CMD_COAST;
        r_cnt[c]   <= '0;
      end
      o_pwm1 <= 1'b0;
      o_pwm2 <= 1'b0;
      o_h_in <= 4'b0000;
      o_busy <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= w_state[c];
        r_cmd[c]   <= w_cmd[c];
        r_new[c]   <= w_new[c];
        r_cnt[c]   <= w_cnt[c];
      end
      o_pwm1 <= w_en[0];
      o_pwm2 <= w_en[1];
      o_h_in <= {w_pins[1], w_pins[0]};
      o_busy <= {w_state[1] != S_RUN, w_state[0] != S_RUN};
    end
  end

  a_no_direct_reverse: assert property (@(posedge i_pclk) disable iff (i_preset)
    !(is_rev($past(o_h_in[1:0]), o_h_in[1:0]) || is_rev($past(o_h_in[3:2]), o_h_in[3:2])));

endmodule

// File: tb/tb_hbridge_dir_sequencer.sv
// tb/tb_hbridge_dir_sequencer.sv - directed bench with a timeline model of the H-bridge sequencer.
module tb_hbridge_dir_sequencer;
  localparam int D = 4;
  localparam int B = 8;
  localparam int W = 100;

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic       pwm1_in = 1'b0;
  logic       pwm2_in = 1'b0;
  logic [1:0] cmd_a = 2'b00;
  logic [1:0] cmd_b = 2'b00;
  logic       valid = 1'b0;
  logic       pwm1, pwm2, fault;
  logic [3:0] h_in;
  logic [1:0] busy;

  always #5 clk = ~clk;

  hbridge_dir_sequencer #(.DEAD_CYCLES(D), .BRAKE_CYCLES(B), .WDT_CYCLES(W)) dut (
    .i_pclk(clk), .i_preset(preset), .i_pwm1_in(pwm1_in), .i_pwm2_in(pwm2_in),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_valid(valid),
    .o_pwm1(pwm1), .o_pwm2(pwm2), .o_h_in(h_in), .o_busy(busy), .o_fault(fault)
  );

  int total = 0;
  int bad = 0;
  bit started = 0;
  bit last_p1 = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Timeline model: each accepted change is a span of cycles since acceptance,
  // blank for D, then (reversal only) brake for B and blank for D.
  int m_app[2];
  int m_tgt[2];
  int m_el[2];
  int m_len[2];
  bit m_act[2];
  bit m_pin[2];
  int m_idle;
  bit m_fault;

  always @(posedge clk) begin
    bit fire;
    bit was;
    int ci;
    started = 1;
    m_pin[0] = pwm1_in;
    m_pin[1] = pwm2_in;
    fire = 0;
    if (preset) begin
      for (int c = 0; c < 2; c++) begin
        m_app[c] = 0; m_tgt[c] = 0; m_act[c] = 0; m_el[c] = 0; m_len[c] = 0;
      end
      m_idle = 0;
      m_fault = 0;
    end else begin
`ifdef HB_CMD_WATCHDOG_EN
      if (valid) begin
        m_idle = 0;
        m_fault = 0;
      end else if (!m_fault) begin
        m_idle++;
        if (m_idle == W) begin
          m_fault = 1;
          fire = 1;
        end
      end
`endif
      for (int c = 0; c < 2; c++) begin
        was = m_act[c];
        if (m_act[c]) begin
          m_el[c]++;
          if (m_el[c] > m_len[c]) begin
            m_act[c] = 0;
            m_app[c] = m_tgt[c];
          end
        end
        ci = (c == 0) ? int'(cmd_a) : int'(cmd_b);
        if (!was && valid && ci != m_app[c]) begin
          m_act[c] = 1;
          m_el[c]  = 1;
          m_tgt[c] = ci;
          m_len[c] = ((m_app[c] == 1 && ci == 2) || (m_app[c] == 2 && ci == 1)) ? 2 * D + B : D;
        end
        if (fire && (m_act[c] ? m_tgt[c] : m_app[c]) != 0) begin
          m_act[c] = 1;
          m_el[c]  = 1;
          m_tgt[c] = 0;
          m_len[c] = D;
        end
      end
    end
  end

  function automatic int model_out();
    bit en[2];
    int pins[2];
    for (int c = 0; c < 2; c++) begin
      if (m_act[c]) begin
        if (m_el[c] <= D || m_el[c] > D + B) begin en[c] = 0; pins[c] = 0; end
        else begin en[c] = 1; pins[c] = 3; end
      end else begin
        case (m_app[c])
          1: begin en[c] = m_pin[c]; pins[c] = 1; end
          2: begin en[c] = m_pin[c]; pins[c] = 2; end
          3: begin en[c] = 1; pins[c] = 3; end
          default: begin en[c] = 0; pins[c] = 0; end
        endcase
      end
    end
    return (int'(en[0]) << 8) | (int'(en[1]) << 7) | (pins[1] << 5) | (pins[0] << 3)
         | (int'(m_act[1]) << 2) | (int'(m_act[0]) << 1) | int'(m_fault);
  endfunction

  always @(negedge clk) begin
    if (started) chk("model", int'({pwm1, pwm2, h_in, busy, fault}), model_out());
  end

  task automatic step();
    last_p1 = pwm1_in;
    @(posedge clk);
    #1;
    pwm1_in = ~pwm1_in;
    pwm2_in = 1'($urandom_range(0, 1));
  endtask

  task automatic strobe(input logic [1:0] a, input logic [1:0] b);
    cmd_a = a;
    cmd_b = b;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic chk_a(input string name, input int eb, input int eh, input int ee);
    chk(name, int'({busy[0], h_in[1:0], pwm1}), (eb << 3) | (eh << 1) | ee);
  endtask

  initial begin
    int n;
    int eh;
    int ee;
    repeat (3) step();
    preset = 1'b0;
    chk("reset", int'({pwm1, pwm2, h_in, busy, fault}), 0);

    // 1: coast -> fwd, plain blank
    strobe(2'b01, 2'b00);
    for (int i = 1; i <= D; i++) begin
      chk_a("t1_blank", 1, 0, 0);
      step();
    end
    chk_a("t1_run", 0, 1, int'(last_p1));
    step();
    chk_a("t1_pwm", 0, 1, int'(last_p1));

    // 2: fwd -> rev, full reversal
    strobe(2'b10, 2'b00);
    n = 0;
    for (int i = 1; i <= 18; i++) begin
      if (i <= 4) begin eh = 0; ee = 0; end
      else if (i <= 12) begin eh = 3; ee = 1; end
      else if (i <= 16) begin eh = 0; ee = 0; end
      else begin eh = 2; ee = int'(last_p1); end
      chk_a("t2_seq", (i <= 16) ? 1 : 0, eh, ee);
      n += int'(busy[0]);
      step();
    end
    chk("t2_busy_len", n, 16);

    // 3: back to fwd, then mid-brake strobe ignored on A, accepted on B
    strobe(2'b01, 2'b00);
    repeat (16) step();
    chk_a("t3_fwd", 0, 1, int'(last_p1));
    strobe(2'b10, 2'b00);
    repeat (6) step();
    strobe(2'b00, 2'b01);
    chk_a("t3_a_still_brake", 1, 3, 1);
    for (int i = 1; i <= D; i++) begin
      chk("t3_b_blank", int'({busy[1], h_in[3:2], pwm2}), 8);
      step();
    end
    chk("t3_b_fwd", int'({busy[1], h_in[3:2]}), 1);
    repeat (5) step();
    chk_a("t3_a_rev", 0, 2, int'(last_p1));

    // 4: reset in brake cycle 3
    strobe(2'b01, 2'b01);
    repeat (6) step();
    chk_a("t4_in_brake", 1, 3, 1);
    preset = 1'b1;
    step();
    preset = 1'b0;
    chk("t4_reset", int'({pwm1, pwm2, h_in, busy}), 0);
    strobe(2'b01, 2'b00);
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      chk("t4_h", int'(h_in[1:0]), (i <= D) ? 0 : 1);
      n += int'(busy[0]);
      step();
    end
    chk("t4_busy_len", n, 4);

    // 6: same command re-strobed
    strobe(2'b01, 2'b00);
    for (int i = 1; i <= 3; i++) begin
      chk("t6_same", int'({busy, h_in, pwm1}), (1 << 1) | int'(last_p1));
      step();
    end

    // 5: watchdog / command persistence
`ifdef HB_CMD_WATCHDOG_EN
    strobe(2'b01, 2'b01);
    n = 0;
    while (!fault && n < 150) begin
      step();
      n++;
    end
    chk("t5_wdt_time", n, W);
    for (int i = 1; i <= D; i++) begin
      chk("t5_blank", int'({pwm1, pwm2, busy, h_in, fault}), 'b0011_0000_1);
      step();
    end
    chk("t5_coast", int'({busy, h_in, fault}), 1);
    strobe(2'b00, 2'b00);
    chk("t5_clear", int'(fault), 0);
`else
    strobe(2'b01, 2'b01);
    repeat (1000) step();
    chk("t5_hold", int'({busy, h_in, fault}), 'b00_0101_0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
